relobi_req_arbiter: RTL and testbench



---
 rtl/relobi_arb_pkg.sv | 50 +++++
 rtl/relobi_arb_rr_pick.sv | 28 ++
 rtl/relobi_req_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_relobi_req_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relobi_arb_pkg.sv
// Shared constants, bus types and helpers for the reliable-OBI request arbiter.
package relobi_arb_pkg;

   localparam int unsigned FaultCntWidth = 8;
   localparam logic [FaultCntWidth-1:0] FaultCntMax = '1;

   // Bit positions inside the decoder fault vector
   localparam int unsigned FaultCorr   = 0;
   localparam int unsigned FaultUncorr = 1;

   // Minimal bus configuration; only the rready selection matters here
   typedef struct packed {
      logic UseRReady;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b1};

   // Default plain-OBI channel layout used when no types are supplied
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_def_a_chan_t;

   typedef struct packed {
      obi_def_a_chan_t a;
      logic            req;
      logic            rready;
   } obi_def_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } obi_def_r_chan_t;

   typedef struct packed {
      logic            gnt;
      logic            rvalid;
      obi_def_r_chan_t r;
   } obi_def_rsp_t;

   // Increment that sticks at the maximum count
   function automatic logic [FaultCntWidth-1:0] fault_cnt_inc(input logic [FaultCntWidth-1:0] cnt);
      return (cnt == FaultCntMax) ? cnt : cnt + FaultCntWidth'(1);
   endfunction

endpackage

// File: rtl/relobi_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module relobi_arb_rr_pick #(
   parameter  int unsigned NumReq = 4,
   localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic              vld_o,
   output logic [IdxW-1:0]   idx_o
);

   // Scan requesters starting at the pointer, wrapping once around
   always_comb begin
      int unsigned cand;
      cand  = 0;
      vld_o = 1'b0;
      idx_o = ptr_i;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= NumReq) cand = cand - NumReq;
         if (!vld_o && req_i[IdxW'(cand)]) begin
            vld_o = 1'b1;
            idx_o = IdxW'(cand);
         end
      end
   end

endmodule

// File: rtl/relobi_req_arbiter.sv
// N-to-1 round-robin arbiter in front of a shared reliable-OBI decode path.
// Outstanding transactions are tracked in an index FIFO so R responses return
// to their issuer; decoder faults are attributed to the granted requester.
// Optional: define RELOBI_REQ_ARBITER_FAULT_CNT_EN to build the saturating
// fault event counter; otherwise fault_cnt_o is tied to zero.
module relobi_req_arbiter
   import relobi_arb_pkg::*;
#(
   parameter  obi_cfg_t    Cfg       = ObiDefaultConfig,
   parameter  int unsigned NumReq    = 4,
   parameter  int unsigned MaxTrans  = 4,
   parameter  type         obi_req_t = obi_def_req_t,
   parameter  type         obi_rsp_t = obi_def_rsp_t,
   localparam int unsigned IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  obi_req_t                 sbr_req_i [NumReq],
   output obi_rsp_t                 sbr_rsp_o [NumReq],
   output obi_req_t                 mgr_req_o,
   input  obi_rsp_t                 mgr_rsp_i,
   input  logic [1:0]               fault_i,
   input  logic                     fault_clr_i,
   output logic [1:0]               fault_o,
   output logic [IdxW-1:0]          fault_idx_o,
   output logic [FaultCntWidth-1:0] fault_cnt_o,
   output logic                     busy_o
);

   localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int unsigned CntW = $clog2(MaxTrans + 1);

   typedef logic [IdxW-1:0] idx_t;

   idx_t            ptr_q, ptr_d;
   logic            lock_q, lock_d;
   idx_t            lock_idx_q, lock_idx_d;
   idx_t            fifo_q [MaxTrans];
   logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      fault_q, fault_d;
   idx_t            fidx_q, fidx_d;

   logic [NumReq-1:0] req_vec;
   logic              pick_vld;
   idx_t              pick_idx;
   logic              full, empty;
   logic              win_vld;
   idx_t              win_idx;
   idx_t              head_idx;
   logic              head_rready;
   logic              hs, push, pop;
   logic              fault_ev;
   logic [1:0]        fault_base;

   // Gather the request bits for the picker
   always_comb begin
      req_vec = '0;
      for (int unsigned i = 0; i < NumReq; i++) req_vec[i] = sbr_req_i[i].req;
   end

   relobi_arb_rr_pick #(
      .NumReq (NumReq)
   ) i_pick (
      .req_i (req_vec),
      .ptr_i (ptr_q),
      .vld_o (pick_vld),
      .idx_o (pick_idx)
   );

   // Winner selection and handshake / pop qualification; a held winner
   // bypasses the picker so its A channel cannot change before the grant
   always_comb begin
      full        = (cnt_q == CntW'(MaxTrans));
      empty       = (cnt_q == '0);
      win_vld     = lock_q | (pick_vld & ~full);
      win_idx     = lock_q ? lock_idx_q : pick_idx;
      head_idx    = fifo_q[rd_q];
      head_rready = Cfg.UseRReady ? sbr_req_i[head_idx].rready : 1'b1;
      hs          = win_vld & mgr_rsp_i.gnt;
      push        = hs;
      pop         = mgr_rsp_i.rvalid & ~empty & head_rready;
   end

   // Manager-side request: winner's A channel; responses with no owner are always accepted
   always_comb begin
      mgr_req_o        = sbr_req_i[win_idx];
      mgr_req_o.req    = win_vld;
      mgr_req_o.rready = empty ? 1'b1 : head_rready;
   end

   // Requester-side responses: gnt to the winner only, rvalid to the FIFO head only
   always_comb begin
      for (int unsigned i = 0; i < NumReq; i++) begin
         sbr_rsp_o[i]        = mgr_rsp_i;
         sbr_rsp_o[i].gnt    = hs & (win_idx == idx_t'(i));
         sbr_rsp_o[i].rvalid = mgr_rsp_i.rvalid & ~empty & (head_idx == idx_t'(i));
      end
   end

   // Next state for pointer, lock, FIFO pointers/count and sticky faults
   always_comb begin
      ptr_d      = ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (hs) begin
         ptr_d  = (win_idx == idx_t'(NumReq - 1)) ? '0 : win_idx + idx_t'(1);
         lock_d = 1'b0;
      end else if (win_vld) begin
         lock_d     = 1'b1;
         lock_idx_d = win_idx;
      end

      wr_d = wr_q;
      if (push) wr_d = (wr_q == PtrW'(MaxTrans - 1)) ? '0 : wr_q + PtrW'(1);
      rd_d = rd_q;
      if (pop) rd_d = (rd_q == PtrW'(MaxTrans - 1)) ? '0 : rd_q + PtrW'(1);

      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase

      // A clear and a new event in the same cycle: the new event is kept
      fault_ev   = win_vld & (fault_i[FaultCorr] | fault_i[FaultUncorr]);
      fault_base = fault_clr_i ? 2'b00 : fault_q;
      fault_d    = fault_base | (fault_ev ? fault_i : 2'b00);
      fidx_d     = fault_clr_i ? '0 : fidx_q;
      if (fault_ev && (fault_base == 2'b00)) fidx_d = win_idx;
   end

   // Control state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         fault_q    <= 2'b00;
         fidx_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         fault_q    <= fault_d;
         fidx_q     <= fidx_d;
      end
   end

   // Index FIFO storage; validity is carried by the count, so no reset needed
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_q] <= win_idx;
   end

`ifdef RELOBI_REQ_ARBITER_FAULT_CNT_EN
   logic [FaultCntWidth-1:0] fcnt_q, fcnt_d;

   // Saturating fault event count; clear plus event in one cycle restarts at one
   always_comb begin
      fcnt_d = fault_clr_i ? '0 : fcnt_q;
      if (fault_ev) fcnt_d = fault_cnt_inc(fcnt_d);
   end

   // Fault counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) fcnt_q <= '0;
      else       fcnt_q <= fcnt_d;
   end

   assign fault_cnt_o = fcnt_q;
`else
   assign fault_cnt_o = '0;
`endif

   assign fault_o     = fault_q;
   assign fault_idx_o = fidx_q;
   assign busy_o      = (cnt_q != '0) | win_vld;

endmodule

// File: tb/tb_relobi_req_arbiter.sv
// Self-checking bench for relobi_req_arbiter: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_relobi_req_arbiter;
  import relobi_arb_pkg::*;

  localparam int N  = 4;
  localparam int MT = 4;
  localparam int IW = 2;
`ifdef RELOBI_REQ_ARBITER_FAULT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  obi_def_req_t sbr_req [N];
  obi_def_rsp_t sbr_rsp [N];
  obi_def_req_t mgr_req;
  obi_def_rsp_t mgr_rsp;
  logic [1:0]   fault;
  logic         fault_clr;
  logic [1:0]   fault_o;
  logic [IW-1:0] fidx;
  logic [7:0]   fcnt;
  logic         busy;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  relobi_req_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sbr_req_i   (sbr_req),
    .sbr_rsp_o   (sbr_rsp),
    .mgr_req_o   (mgr_req),
    .mgr_rsp_i   (mgr_rsp),
    .fault_i     (fault),
    .fault_clr_i (fault_clr),
    .fault_o     (fault_o),
    .fault_idx_o (fidx),
    .fault_cnt_o (fcnt),
    .busy_o      (busy)
  );

  // ---------------- behavioural reference model ----------------
  int         m_ptr  = 0;
  int         m_held = -1;
  int         m_q[$];
  logic [1:0] m_fault = 2'b00;
  int         m_fidx = 0;
  int         m_fcnt = 0;
  bit         m_granted [N];

  // Requester the arbiter should be serving right now (-1: none)
  function automatic int exp_win();
    if (m_held >= 0) return m_held;
    if (m_q.size() >= MT) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (sbr_req[i].req) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_b
    int w;
    if (rst) begin
      m_ptr = 0; m_held = -1; m_q.delete();
      m_fault = 2'b00; m_fidx = 0; m_fcnt = 0;
      for (int i = 0; i < N; i++) m_granted[i] = 1'b0;
    end else begin
      w = exp_win();
      for (int i = 0; i < N; i++) m_granted[i] = 1'b0;
      if (mgr_rsp.rvalid && m_q.size() > 0 && sbr_req[m_q[0]].rready) void'(m_q.pop_front());
      if (w >= 0 && mgr_rsp.gnt) begin
        m_q.push_back(w); m_ptr = (w + 1) % N; m_held = -1; m_granted[w] = 1'b1;
      end else if (w >= 0) begin
        m_held = w;
      end
      if (fault_clr) begin m_fault = 2'b00; m_fidx = 0; m_fcnt = 0; end
      if (w >= 0 && fault != 2'b00) begin
        if (m_fault == 2'b00) m_fidx = w;
        m_fault = m_fault | fault;
        if (CntEn && m_fcnt < 255) m_fcnt++;
      end
    end
  end

  // ---------------- stimulus utilities ----------------
  function automatic obi_def_a_chan_t rand_a();
    obi_def_a_chan_t a;
    a.addr = $urandom; a.we = 1'($urandom); a.be = 4'($urandom);
    a.wdata = $urandom; a.aid = 1'($urandom);
    return a;
  endfunction

  function automatic logic [N-1:0] gnt_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].gnt;
    return v;
  endfunction

  function automatic logic [N-1:0] rv_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].rvalid;
    return v;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      sbr_req[i].req = 1'b0; sbr_req[i].rready = 1'b1; sbr_req[i].a = rand_a();
    end
    mgr_rsp.gnt = 1'b0; mgr_rsp.rvalid = 1'b0;
    mgr_rsp.r.rdata = $urandom; mgr_rsp.r.rid = 1'b0; mgr_rsp.r.err = 1'b0;
    fault = 2'b00; fault_clr = 1'b0;
  endtask

  // Return every outstanding response so the next scenario starts empty
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (m_q.size() == 0) done = 1'b1;
      else begin idle_inputs(); mgr_rsp.rvalid = 1'b1; end
    end
    if (!done) begin
      errs++;
      $display("FAIL drain_timeout: outstanding=%0d required=0", m_q.size());
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mgr_rsp.rvalid = 1'b1;
    #1;
    checks++; if (mgr_req.req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b required 0", mgr_req.req); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (fault_o !== 2'b00) begin errs++; $display("FAIL reset_fault: got %b required 00", fault_o); end
    checks++; if (fidx !== '0) begin errs++; $display("FAIL reset_fidx: got %0d required 0", fidx); end
    checks++; if (fcnt !== 8'd0) begin errs++; $display("FAIL reset_fcnt: got %0d required 0", fcnt); end
    checks++; if (gnt_vec() !== '0 || rv_vec() !== '0) begin errs++; $display("FAIL reset_rsp: gnt=%b rvalid=%b required 0/0", gnt_vec(), rv_vec()); end
    checks++; if (mgr_req.rready !== 1'b1) begin errs++; $display("FAIL reset_rready: got %b required 1", mgr_req.rready); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, -1, -1};
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        for (int i = 0; i < N; i++) sbr_req[i].req = 1'b1;
        mgr_rsp.gnt = 1'b1;
      end
      #1;
      checks++; if (mgr_req.req !== (seq[c] >= 0)) begin errs++; $display("FAIL rr_req c%0d: got %b required %b", c, mgr_req.req, seq[c] >= 0); end
      checks++; if (gnt_vec() !== ((seq[c] >= 0) ? 4'(1 << seq[c]) : 4'b0)) begin errs++; $display("FAIL rr_gnt c%0d: got %b required winner %0d", c, gnt_vec(), seq[c]); end
      if (seq[c] >= 0) begin
        checks++; if (mgr_req.a !== sbr_req[seq[c]].a) begin errs++; $display("FAIL rr_a c%0d: got %h required %h", c, mgr_req.a, sbr_req[seq[c]].a); end
      end
    end
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rr_full_busy: got %b required 1", busy); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle_inputs();
      mgr_rsp.rvalid = 1'b1; mgr_rsp.r.rdata = 32'h1111_0000 + 32'(j);
      #1;
      checks++; if (rv_vec() !== 4'(1 << j)) begin errs++; $display("FAIL rr_route r%0d: got %b required %b", j, rv_vec(), 4'(1 << j)); end
      checks++; if (sbr_rsp[j].r.rdata !== 32'h1111_0000 + 32'(j)) begin errs++; $display("FAIL rr_rdata r%0d: got %h", j, sbr_rsp[j].r.rdata); end
    end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rr_drained_busy: got %b required 0", busy); end
  endtask

  task automatic test_lock();
    obi_def_a_chan_t a0, a3;
    @(negedge clk);
    sbr_req[0].req = 1'b1; sbr_req[1].req = 1'b1; a0 = sbr_req[0].a;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      mgr_rsp.gnt = (c >= 3);
      if (c == 4) sbr_req[0].req = 1'b0;
      #1;
      if (c < 3) begin
        checks++; if (mgr_req.req !== 1'b1 || mgr_req.a !== a0 || gnt_vec() !== 4'b0000) begin errs++; $display("FAIL lock_hold c%0d: req=%b a=%h gnt=%b required 1/%h/0000", c, mgr_req.req, mgr_req.a, gnt_vec(), a0); end
      end else if (c == 3) begin
        checks++; if (gnt_vec() !== 4'b0001) begin errs++; $display("FAIL lock_release: got %b required 0001", gnt_vec()); end
      end else begin
        checks++; if (gnt_vec() !== 4'b0010 || mgr_req.a !== sbr_req[1].a) begin errs++; $display("FAIL lock_next: gnt=%b required 0010", gnt_vec()); end
      end
    end
    // Held winner must not yield to a requester closer to the pointer
    @(negedge clk);
    sbr_req[1].req = 1'b0; sbr_req[3].req = 1'b1; mgr_rsp.gnt = 1'b0; a3 = sbr_req[3].a;
    @(negedge clk);
    sbr_req[2].req = 1'b1;
    #1;
    checks++; if (mgr_req.a !== a3 || gnt_vec() !== 4'b0000) begin errs++; $display("FAIL lock_preempt: a=%h gnt=%b required %h/0000", mgr_req.a, gnt_vec(), a3); end
    @(negedge clk);
    mgr_rsp.gnt = 1'b1; #1;
    checks++; if (gnt_vec() !== 4'b1000) begin errs++; $display("FAIL lock_grant3: got %b required 1000", gnt_vec()); end
    @(negedge clk);
    sbr_req[3].req = 1'b0; #1;
    checks++; if (gnt_vec() !== 4'b0100) begin errs++; $display("FAIL lock_grant2: got %b required 0100", gnt_vec()); end
    @(negedge clk); idle_inputs();
    drain();
  endtask

  task automatic test_routing();
    @(negedge clk);
    sbr_req[2].req = 1'b1; mgr_rsp.gnt = 1'b1; #1;
    checks++; if (gnt_vec() !== 4'b0100) begin errs++; $display("FAIL route_g2: got %b required 0100", gnt_vec()); end
    @(negedge clk);
    sbr_req[2].req = 1'b0; sbr_req[0].req = 1'b1; #1;
    checks++; if (gnt_vec() !== 4'b0001) begin errs++; $display("FAIL route_g0: got %b required 0001", gnt_vec()); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      mgr_rsp.rvalid = 1'b1; mgr_rsp.r.rdata = 32'hAAAA5555;
      sbr_req[2].rready = (c == 2);
      #1;
      checks++; if (rv_vec() !== 4'b0100 || sbr_rsp[2].r.rdata !== 32'hAAAA5555) begin errs++; $display("FAIL route_r2 c%0d: rvalid=%b rdata=%h required 0100/aaaa5555", c, rv_vec(), sbr_rsp[2].r.rdata); end
      checks++; if (mgr_req.rready !== (c == 2)) begin errs++; $display("FAIL route_rready c%0d: got %b required %b", c, mgr_req.rready, c == 2); end
    end
    @(negedge clk);
    mgr_rsp.r.rdata = 32'h12345678; #1;
    checks++; if (rv_vec() !== 4'b0001 || sbr_rsp[0].r.rdata !== 32'h12345678) begin errs++; $display("FAIL route_r0: rvalid=%b rdata=%h required 0001/12345678", rv_vec(), sbr_rsp[0].r.rdata); end
    @(negedge clk);
    mgr_rsp.r.rdata = $urandom; #1;
    checks++; if (rv_vec() !== 4'b0000 || mgr_req.rready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL route_empty: rvalid=%b rready=%b busy=%b required 0000/1/0", rv_vec(), mgr_req.rready, busy); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL route_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_fault();
    @(negedge clk);
    sbr_req[3].req = 1'b1; fault = 2'b10; mgr_rsp.gnt = 1'b1; #1;
    checks++; if (gnt_vec() !== 4'b1000) begin errs++; $display("FAIL fault_g3: got %b required 1000", gnt_vec()); end
    @(negedge clk);
    sbr_req[3].req = 1'b0; sbr_req[1].req = 1'b1; fault = 2'b01; #1;
    checks++; if (gnt_vec() !== 4'b0010 || fault_o !== 2'b10) begin errs++; $display("FAIL fault_g1: gnt=%b fault=%b required 0010/10", gnt_vec(), fault_o); end
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (fault_o !== 2'b11 || fidx !== 2'd3 || fcnt !== (CntEn ? 8'd2 : 8'd0)) begin errs++; $display("FAIL fault_attr: fault=%b idx=%0d cnt=%0d required 11/3/%0d", fault_o, fidx, fcnt, CntEn ? 2 : 0); end
    @(negedge clk);
    sbr_req[2].req = 1'b1; fault = 2'b01; fault_clr = 1'b1;
    @(negedge clk);
    fault = 2'b00; fault_clr = 1'b0; mgr_rsp.gnt = 1'b1; #1;
    checks++; if (fault_o !== 2'b01 || fidx !== 2'd2 || fcnt !== (CntEn ? 8'd1 : 8'd0)) begin errs++; $display("FAIL fault_clr_race: fault=%b idx=%0d cnt=%0d required 01/2/%0d", fault_o, fidx, fcnt, CntEn ? 1 : 0); end
    @(negedge clk);
    idle_inputs(); fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0; fault = 2'b11; #1;
    checks++; if (fault_o !== 2'b00 || fidx !== '0 || fcnt !== 8'd0) begin errs++; $display("FAIL fault_clear: fault=%b idx=%0d cnt=%0d required 00/0/0", fault_o, fidx, fcnt); end
    @(negedge clk);
    fault = 2'b00; #1;
    checks++; if (fault_o !== 2'b00) begin errs++; $display("FAIL fault_noreq: got %b required 00", fault_o); end
    drain();
  endtask

  task automatic test_saturation_reset();
    @(negedge clk);
    sbr_req[0].req = 1'b1; fault = 2'b01;
    repeat (300) @(negedge clk);
    fault = 2'b00; mgr_rsp.gnt = 1'b1; #1;
    checks++; if (fcnt !== (CntEn ? 8'd255 : 8'd0) || fault_o !== 2'b01 || fidx !== '0) begin errs++; $display("FAIL sat_cnt: cnt=%0d fault=%b idx=%0d required %0d/01/0", fcnt, fault_o, fidx, CntEn ? 255 : 0); end
    @(negedge clk);
    sbr_req[0].req = 1'b0; sbr_req[1].req = 1'b1;
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL sat_outstanding: busy=%b required 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mgr_rsp.rvalid = 1'b1; #1;
    checks++; if (busy !== 1'b0 || mgr_req.req !== 1'b0 || rv_vec() !== 4'b0000 || mgr_req.rready !== 1'b1) begin errs++; $display("FAIL rst_fifo: busy=%b req=%b rvalid=%b rready=%b required 0/0/0000/1", busy, mgr_req.req, rv_vec(), mgr_req.rready); end
    checks++; if (fault_o !== 2'b00 || fidx !== '0 || fcnt !== 8'd0) begin errs++; $display("FAIL rst_fault: fault=%b idx=%0d cnt=%0d required 00/0/0", fault_o, fidx, fcnt); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] eg, er;
    logic erdy;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!(sbr_req[i].req && !m_granted[i])) begin
          sbr_req[i].req = ($urandom_range(0, 2) == 0);
          sbr_req[i].a = rand_a();
        end
        sbr_req[i].rready = ($urandom_range(0, 3) != 0);
      end
      mgr_rsp.gnt = ($urandom_range(0, 2) != 0);
      mgr_rsp.rvalid = ($urandom_range(0, 1) == 1);
      mgr_rsp.r.rdata = $urandom; mgr_rsp.r.rid = 1'($urandom); mgr_rsp.r.err = 1'($urandom);
      fault = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fault_clr = ($urandom_range(0, 19) == 0);
      #1;
      w = exp_win();
      eg = '0; er = '0;
      if (w >= 0 && mgr_rsp.gnt) eg[w] = 1'b1;
      if (mgr_rsp.rvalid && m_q.size() > 0) er[m_q[0]] = 1'b1;
      erdy = (m_q.size() == 0) ? 1'b1 : sbr_req[m_q[0]].rready;
      checks++; if (mgr_req.req !== (w >= 0)) begin errs++; $display("FAIL rnd_req c%0d: got %b required %b", c, mgr_req.req, w >= 0); end
      if (w >= 0) begin
        checks++; if (mgr_req.a !== sbr_req[w].a) begin errs++; $display("FAIL rnd_a c%0d: got %h required %h", c, mgr_req.a, sbr_req[w].a); end
      end
      checks++; if (gnt_vec() !== eg) begin errs++; $display("FAIL rnd_gnt c%0d: got %b required %b", c, gnt_vec(), eg); end
      checks++; if (rv_vec() !== er) begin errs++; $display("FAIL rnd_rvalid c%0d: got %b required %b", c, rv_vec(), er); end
      if (er != '0) begin
        checks++; if (sbr_rsp[m_q[0]].r !== mgr_rsp.r) begin errs++; $display("FAIL rnd_r c%0d: got %h required %h", c, sbr_rsp[m_q[0]].r, mgr_rsp.r); end
      end
      checks++; if (mgr_req.rready !== erdy) begin errs++; $display("FAIL rnd_rready c%0d: got %b required %b", c, mgr_req.rready, erdy); end
      checks++; if (busy !== (m_q.size() != 0 || w >= 0)) begin errs++; $display("FAIL rnd_busy c%0d: got %b", c, busy); end
      checks++; if (fault_o !== m_fault || fidx !== IW'(m_fidx) || fcnt !== 8'(m_fcnt)) begin errs++; $display("FAIL rnd_fault c%0d: fault=%b idx=%0d cnt=%0d required %b/%0d/%0d", c, fault_o, fidx, fcnt, m_fault, m_fidx, m_fcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_routing();
    test_fault();
    test_saturation_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
